// File: rtl/logIP_pkg.sv
// ---------------------------------------------------------------------------
// logIP_pkg
// Shared types and constants for the SUMP front end (command sequencer,
// instruction decoder, configuration registers).
//   cmd_seq_state_t      : command sequencer FSM states
//   OPC_LONG_BIT         : opcode bit that marks a 5-byte (long) command
//   SUMP_LONG_DATA_BYTES : number of argument bytes after a long opcode
//   opcode_t             : SUMP opcodes understood by the decoder
// ---------------------------------------------------------------------------
package logIP_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } cmd_seq_state_t;

    localparam int OPC_LONG_BIT         = 7;
    localparam int SUMP_LONG_DATA_BYTES = 4;

    typedef enum logic [7:0] {
        OPC_RESET      = 8'h00,
        OPC_RUN        = 8'h01,
        OPC_ID         = 8'h02,
        OPC_META       = 8'h04,
        OPC_XON        = 8'h11,
        OPC_XOFF       = 8'h13,
        OPC_DIVIDER    = 8'h80,
        OPC_READ_DELAY = 8'h81,
        OPC_FLAGS      = 8'h82,
        OPC_TRIG_MASK0 = 8'hC0,
        OPC_TRIG_VAL0  = 8'hC1,
        OPC_TRIG_CFG0  = 8'hC2,
        OPC_TRIG_MASK1 = 8'hC4,
        OPC_TRIG_VAL1  = 8'hC5,
        OPC_TRIG_CFG1  = 8'hC6
    } opcode_t;

endpackage

// File: rtl/cmd_timeout.sv
// ---------------------------------------------------------------------------
// cmd_timeout
// Loadable / clearable down-counter with an expiry flag. Loading arms the
// guard window; expired_o is high once the counter has run down to zero.
// Ports:
//   clk_i       system clock
//   rst_in      asynchronous reset, active low (counter -> 0)
//   clr_i       synchronous clear to 0 (highest priority)
//   load_i      load load_val_i
//   load_val_i  reload value (window length - 1)
//   run_i       decrement enable; counter holds at 0
//   expired_o   counter is zero
// ---------------------------------------------------------------------------
module cmd_timeout #(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             run_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cmd_seq.sv
// ---------------------------------------------------------------------------
// cmd_seq
// SUMP command sequencer. Assembles UART bytes into complete commands:
// short (1 byte, opcode bit7 = 0) or long (opcode bit7 = 1 followed by
// 4 argument bytes, LSB first). A complete command is presented on
// opc_o/cmd_o with a one-cycle stb_o. A long command whose next byte does
// not arrive within TIMEOUT_CYCLES clocks is dropped and tout_o pulses.
// Ports:
//   clk_i     system clock
//   rst_in    asynchronous reset, active low
//   rx_stb_i  one-cycle pulse, rx_dat_i valid
//   rx_dat_i  received byte
//   stb_o     one-cycle pulse, complete command on opc_o/cmd_o
//   opc_o     command opcode (held until the next stb_o)
//   cmd_o     command argument, 0 for short commands (held until next stb_o)
//   busy_o    long command partially received
//   tout_o    one-cycle pulse, partial long command discarded
// TIMEOUT_CYCLES must be >= 2.
// ---------------------------------------------------------------------------
module cmd_seq
    import logIP_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        rx_stb_i,
    input  logic [7:0]  rx_dat_i,
    output logic        stb_o,
    output logic [7:0]  opc_o,
    output logic [31:0] cmd_o,
    output logic        busy_o,
    output logic        tout_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam int               IDX_W    = $clog2(SUMP_LONG_DATA_BYTES);
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUMP_LONG_DATA_BYTES - 1);

    cmd_seq_state_t state_q, state_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [7:0]       opc_sh_q, opc_sh_nxt;
    logic [31:0]      data_sh_q, data_sh_nxt;
    logic             stb_nxt;
    logic [7:0]       opc_nxt;
    logic [31:0]      cmd_nxt;
    logic             busy_nxt;
    logic             tout_nxt;

    logic             tmr_clr;
    logic             tmr_load;
    logic             tmr_run;
    logic             tmr_expired;

    // The down-counter is loaded with TIMEOUT_CYCLES-1 on entry and on every
    // accepted byte, so it reaches zero exactly when TIMEOUT_CYCLES-1 idle
    // cycles have elapsed since the last byte.
    cmd_timeout #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (TMR_LOAD),
        .run_i      (tmr_run),
        .expired_o  (tmr_expired)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state_q;
        idx_nxt     = idx_q;
        opc_sh_nxt  = opc_sh_q;
        data_sh_nxt = data_sh_q;
        stb_nxt     = 1'b0;
        tout_nxt    = 1'b0;
        opc_nxt     = opc_o;
        cmd_nxt     = cmd_o;
        tmr_load    = 1'b0;
        tmr_run     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_stb_i) begin
                    if (!rx_dat_i[OPC_LONG_BIT]) begin
                        stb_nxt = 1'b1;
                        opc_nxt = rx_dat_i;
                        cmd_nxt = '0;
                    end else begin
                        opc_sh_nxt  = rx_dat_i;
                        data_sh_nxt = '0;
                        idx_nxt     = '0;
                        tmr_load    = 1'b1;
                        state_nxt   = COLLECT;
                    end
                end
            end

            COLLECT: begin
                // A byte in the expiry cycle takes priority over the timeout.
                if (rx_stb_i) begin
                    data_sh_nxt[{idx_q, 3'b000} +: 8] = rx_dat_i;
                    idx_nxt  = idx_q + IDX_W'(1);
                    tmr_load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        stb_nxt   = 1'b1;
                        opc_nxt   = opc_sh_q;
                        cmd_nxt   = data_sh_nxt;
                        state_nxt = IDLE;
                    end
                end else if (tmr_expired) begin
                    tout_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmr_run = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Park the counter at zero whenever no long command is in flight.
        tmr_clr  = (state_nxt == IDLE);
        busy_nxt = (state_nxt == COLLECT);
    end

    // Registered state and outputs
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            opc_sh_q  <= '0;
            data_sh_q <= '0;
            stb_o     <= 1'b0;
            opc_o     <= '0;
            cmd_o     <= '0;
            busy_o    <= 1'b0;
            tout_o    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            idx_q     <= idx_nxt;
            opc_sh_q  <= opc_sh_nxt;
            data_sh_q <= data_sh_nxt;
            stb_o     <= stb_nxt;
            opc_o     <= opc_nxt;
            cmd_o     <= cmd_nxt;
            busy_o    <= busy_nxt;
            tout_o    <= tout_nxt;
        end
    end

endmodule

// File: tb/tb_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_cmd_seq
// Directed bench for cmd_seq with a short timeout window (16 cycles).
// Inputs change 1 ns after the rising edge; outputs are read there too,
// i.e. well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_cmd_seq;

    localparam int TOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        rx_stb;
    logic [7:0]  rx_dat;
    logic        stb;
    logic [7:0]  opc;
    logic [31:0] cmd;
    logic        busy;
    logic        tout;

    int total = 0;
    int bad   = 0;
    int n_stb = 0;
    int n_tout = 0;
    int n_both = 0;

    cmd_seq #(
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk_i    (clk),
        .rst_in   (rst_n),
        .rx_stb_i (rx_stb),
        .rx_dat_i (rx_dat),
        .stb_o    (stb),
        .opc_o    (opc),
        .cmd_o    (cmd),
        .busy_o   (busy),
        .tout_o   (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event tallies sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stb)         n_stb  <= n_stb + 1;
            if (tout)        n_tout <= n_tout + 1;
            if (stb && tout) n_both <= n_both + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one rising edge. Consecutive calls keep
    // rx_stb high across edges (one byte per cycle).
    task automatic send(input logic [7:0] b);
        rx_stb = 1'b1;
        rx_dat = b;
        tick();
        rx_stb = 1'b0;
        rx_dat = 8'h00;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rx_stb = 1'b0;
        rx_dat = 8'h00;
        tick();
        tick();
        total++;
        if ({stb, opc, cmd, busy, tout} !== 42'd0) begin
            bad++;
            $display("FAIL reset_outputs: got stb=%b opc=%h cmd=%h busy=%b tout=%b, want all 0",
                     stb, opc, cmd, busy, tout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_short();
        int s0;
        s0 = n_stb;
        send(8'h02);
        total++;
        if (stb !== 1'b1 || opc !== 8'h02 || cmd !== 32'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL short_id: got stb=%b opc=%h cmd=%h busy=%b, want 1 02 00000000 0",
                     stb, opc, cmd, busy);
        end
        tick();
        total++;
        if (stb !== 1'b0 || opc !== 8'h02 || busy !== 1'b0 || (n_stb - s0) !== 1) begin
            bad++;
            $display("FAIL short_hold: got stb=%b opc=%h busy=%b strobes=%0d, want 0 02 0 1",
                     stb, opc, busy, n_stb - s0);
        end
    endtask

    task automatic test_long_spaced();
        logic [7:0] seq [5] = '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
        int s0;
        int busy_bad;
        s0 = n_stb;
        busy_bad = 0;
        for (int k = 0; k < 5; k++) begin
            send(seq[k]);
            if (k < 4) begin
                if (busy !== 1'b1 || stb !== 1'b0) busy_bad++;
                for (int w = 0; w < 9; w++) begin
                    tick();
                    if (busy !== 1'b1 || stb !== 1'b0) busy_bad++;
                end
            end
        end
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL long_busy: got %0d cycles with busy=0 or stb=1 while collecting, want 0",
                     busy_bad);
        end
        total++;
        if (stb !== 1'b1 || opc !== 8'hC0 || cmd !== 32'h12345678 || busy !== 1'b0) begin
            bad++;
            $display("FAIL long_done: got stb=%b opc=%h cmd=%h busy=%b, want 1 C0 12345678 0",
                     stb, opc, cmd, busy);
        end
        tick();
        total++;
        if ((n_stb - s0) !== 1) begin
            bad++;
            $display("FAIL long_strobes: got %0d strobes, want 1", n_stb - s0);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = n_stb;
        send(8'h81);
        send(8'hFF);
        send(8'h80);
        send(8'h00);
        total++;
        if (stb !== 1'b0 || busy !== 1'b1 || opc !== 8'hC0) begin
            bad++;
            $display("FAIL b2b_mid: got stb=%b busy=%b opc=%h, want 0 1 C0", stb, busy, opc);
        end
        send(8'h01);
        total++;
        if (stb !== 1'b1 || opc !== 8'h81 || cmd !== 32'h010080FF) begin
            bad++;
            $display("FAIL b2b_done: got stb=%b opc=%h cmd=%h, want 1 81 010080FF", stb, opc, cmd);
        end
        tick();
        total++;
        if ((n_stb - s0) !== 1) begin
            bad++;
            $display("FAIL b2b_strobes: got %0d strobes, want 1", n_stb - s0);
        end
    endtask

    task automatic test_timeout();
        int s0;
        int seen;
        s0 = n_stb;
        seen = 0;
        send(8'hC4);
        send(8'hAA);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL tout_busy: got busy=%b, want 1", busy);
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (tout === 1'b1) begin
                seen = i;
                break;
            end
        end
        total++;
        if (seen != TOUT) begin
            bad++;
            $display("FAIL tout_latency: got tout after %0d cycles, want %0d", seen, TOUT);
        end
        total++;
        if (stb !== 1'b0 || busy !== 1'b0 || opc !== 8'h81 || cmd !== 32'h010080FF
            || (n_stb - s0) !== 0) begin
            bad++;
            $display("FAIL tout_state: got stb=%b busy=%b opc=%h cmd=%h strobes=%0d, want 0 0 81 010080FF 0",
                     stb, busy, opc, cmd, n_stb - s0);
        end
        tick();
        total++;
        if (tout !== 1'b0) begin
            bad++;
            $display("FAIL tout_pulse: got tout=%b one cycle later, want 0", tout);
        end
        send(8'h01);
        total++;
        if (stb !== 1'b1 || opc !== 8'h01 || cmd !== 32'h0) begin
            bad++;
            $display("FAIL tout_recover: got stb=%b opc=%h cmd=%h, want 1 01 00000000", stb, opc, cmd);
        end

        // Byte arriving exactly in the expiry cycle is accepted.
        s0 = n_tout;
        send(8'hC1);
        for (int i = 0; i < TOUT - 1; i++) tick();
        send(8'h44);
        for (int i = 0; i < TOUT - 1; i++) tick();
        send(8'h33);
        send(8'h22);
        send(8'h11);
        total++;
        if (stb !== 1'b1 || opc !== 8'hC1 || cmd !== 32'h11223344 || (n_tout - s0) !== 0) begin
            bad++;
            $display("FAIL tout_edge: got stb=%b opc=%h cmd=%h timeouts=%0d, want 1 C1 11223344 0",
                     stb, opc, cmd, n_tout - s0);
        end
        tick();
    endtask

    task automatic test_soft_reset();
        int s0;
        int pulse_bad;
        s0 = n_stb;
        pulse_bad = 0;
        for (int k = 0; k < 5; k++) begin
            send(8'h00);
            if (stb !== 1'b1 || opc !== 8'h00 || cmd !== 32'h0 || busy !== 1'b0) pulse_bad++;
        end
        total++;
        if (pulse_bad != 0) begin
            bad++;
            $display("FAIL resync_pulses: got %0d bad 0x00 strobes, want 0", pulse_bad);
        end
        send(8'h01);
        total++;
        if (stb !== 1'b1 || opc !== 8'h01) begin
            bad++;
            $display("FAIL resync_run: got stb=%b opc=%h, want 1 01", stb, opc);
        end
        tick();
        total++;
        if ((n_stb - s0) !== 6) begin
            bad++;
            $display("FAIL resync_count: got %0d strobes, want 6", n_stb - s0);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        send(8'hC0);
        send(8'h11);
        send(8'h22);
        rst_n = 1'b0;
        #1;
        total++;
        if ({stb, opc, cmd, busy, tout} !== 42'd0) begin
            bad++;
            $display("FAIL rst_mid_async: got stb=%b opc=%h cmd=%h busy=%b tout=%b, want all 0",
                     stb, opc, cmd, busy, tout);
        end
        tick();
        rst_n = 1'b1;
        s0 = n_stb;
        tick();
        total++;
        if (stb !== 1'b0 || busy !== 1'b0 || opc !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_idle: got stb=%b busy=%b opc=%h, want 0 0 00", stb, busy, opc);
        end
        send(8'h02);
        total++;
        if (stb !== 1'b1 || opc !== 8'h02 || cmd !== 32'h0 || (n_stb - s0) !== 0) begin
            bad++;
            $display("FAIL rst_mid_next: got stb=%b opc=%h cmd=%h earlier_strobes=%0d, want 1 02 00000000 0",
                     stb, opc, cmd, n_stb - s0);
        end
        tick();
        total++;
        if (n_both !== 0) begin
            bad++;
            $display("FAIL stb_tout_overlap: got %0d cycles with both high, want 0", n_both);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rx_stb = 1'b0;
        rx_dat = 8'h00;
        #1;
        test_reset();
        test_short();
        test_long_spaced();
        test_back_to_back();
        test_timeout();
        test_soft_reset();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
